// File: rtl/wb_stage_if.sv
// Bus between the MEM stage, register-file write port, decode-stage read bypass and wb_stage.
// The master drives MEM results and ID read data; wb_stage is the slave.
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            mem_valid;
  logic [XLEN-1:0] mem_pc;
  logic [4:0]      mem_rd;
  logic            mem_reg_we;
  logic [1:0]      mem_wb_sel;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_data;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] addr_rd;
  logic [XLEN-1:0] data_rd;
  logic            write_enable;
  logic [4:0]      id_addr_rs1;
  logic [4:0]      id_addr_rs2;
  logic [XLEN-1:0] id_data_rs1_in;
  logic [XLEN-1:0] id_data_rs2_in;
  logic [XLEN-1:0] id_data_rs1;
  logic [XLEN-1:0] id_data_rs2;
  logic [XLEN-1:0] wb_instret;

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_rd, mem_reg_we, mem_wb_sel,
           mem_alu_result, mem_load_data, mem_funct3,
           id_addr_rs1, id_addr_rs2, id_data_rs1_in, id_data_rs2_in,
    input  addr_rd, data_rd, write_enable, id_data_rs1, id_data_rs2, wb_instret
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_rd, mem_reg_we, mem_wb_sel,
           mem_alu_result, mem_load_data, mem_funct3,
           id_addr_rs1, id_addr_rs2, id_data_rs1_in, id_data_rs2_in,
    output addr_rd, data_rd, write_enable, id_data_rs1, id_data_rs2, wb_instret
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback formatter and retire counter for the RV32I core.
// Optional feature macro WB_BYPASS_EN: forwards the WB write into decode-stage read data.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic      clock,
  input  logic      reset,
  wb_stage_if.slave bus
);

  logic [XLEN-1:0] wb_value_s;
  logic            wb_we_s;
  logic [4:0]      rd_r;
  logic            we_r;
  logic [XLEN-1:0] data_r;
  logic [XLEN-1:0] instret_r;

  // Byte/halfword select with sign or zero extension; unknown funct3 codes pass the raw word.
  function automatic logic [31:0] format_load(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [2:0]  funct3
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] result_v;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (funct3)
      3'b000:  result_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  result_v = {24'd0, byte_v};
      3'b001:  result_v = {{16{half_v[15]}}, half_v};
      3'b101:  result_v = {16'd0, half_v};
      default: result_v = word;
    endcase
    return result_v;
  endfunction

  // Select the writeback value and the effective write strobe from the MEM inputs.
  always_comb begin
    wb_value_s = {XLEN{1'b0}};
    wb_we_s    = 1'b0;
    case (bus.mem_wb_sel)
      2'd0: begin
        wb_value_s = bus.mem_alu_result;
        wb_we_s    = bus.mem_reg_we;
      end
      2'd1: begin
        wb_value_s = format_load(bus.mem_load_data, bus.mem_alu_result[1:0], bus.mem_funct3);
        wb_we_s    = bus.mem_reg_we;
      end
      2'd2: begin
        wb_value_s = bus.mem_pc + 32'd4;
        wb_we_s    = bus.mem_reg_we;
      end
      default: begin
        wb_value_s = {XLEN{1'b0}};
        wb_we_s    = 1'b0;
      end
    endcase
  end

  // Pipeline register and retire counter; the strobe is folded with valid and rd != 0 at capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_r      <= 5'd0;
      we_r      <= 1'b0;
      data_r    <= {XLEN{1'b0}};
      instret_r <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      we_r <= 1'b0;
    end else if (bus.stall) begin
      we_r <= we_r;
    end else begin
      rd_r      <= bus.mem_rd;
      we_r      <= bus.mem_valid & wb_we_s & (bus.mem_rd != 5'd0);
      data_r    <= wb_value_s;
      instret_r <= instret_r + {{(XLEN-1){1'b0}}, bus.mem_valid};
    end
  end

  assign bus.addr_rd      = {{(XLEN-5){1'b0}}, rd_r};
  assign bus.data_rd      = data_r;
  assign bus.write_enable = we_r;
  assign bus.wb_instret   = instret_r;

`ifdef WB_BYPASS_EN
  // Write-before-read forwarding; x0 never matches because we_r is 0 for rd = 0.
  always_comb begin
    if (we_r && (bus.id_addr_rs1 == rd_r)) begin
      bus.id_data_rs1 = data_r;
    end else begin
      bus.id_data_rs1 = bus.id_data_rs1_in;
    end
    if (we_r && (bus.id_addr_rs2 == rd_r)) begin
      bus.id_data_rs2 = data_r;
    end else begin
      bus.id_data_rs2 = bus.id_data_rs2_in;
    end
  end
`else
  assign bus.id_data_rs1 = bus.id_data_rs1_in;
  assign bus.id_data_rs2 = bus.id_data_rs2_in;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan steps followed by randomized traffic
// compared against a behavioural model of the writeback rules.
module tb_wb_stage;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  // Model state: what the register-file port must show after the last edge
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_data;
  logic [31:0] m_instret;
  bit          m_known;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_value(input logic [1:0] sel, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [31:0] ld,
                                            input logic [2:0] f3);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = alu % 32'd4;
    b = (ld >> (8 * off)) & 32'h0000_00FF;
    h = (ld >> (16 * (off / 2))) & 32'h0000_FFFF;
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc + 32'd4;
    if (sel == 2'd3) return 32'd0;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return ld;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 5'd0; m_we = 1'b0; m_data = 32'd0; m_instret = 32'd0; m_known = 1'b1;
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      m_we = 1'b0;
      m_known = 1'b0;
    end else if (!bus.stall) begin
      m_rd = bus.mem_rd;
      m_we = bus.mem_valid && bus.mem_reg_we && (bus.mem_rd != 5'd0) && (bus.mem_wb_sel != 2'd3);
      m_data = ref_value(bus.mem_wb_sel, bus.mem_pc, bus.mem_alu_result,
                         bus.mem_load_data, bus.mem_funct3);
      m_known = 1'b1;
      if (bus.mem_valid) m_instret = m_instret + 32'd1;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic we, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] f3,
                       input logic st, input logic fl);
    bus.mem_valid = v; bus.mem_pc = pc; bus.mem_rd = rd; bus.mem_reg_we = we;
    bus.mem_wb_sel = sel; bus.mem_alu_result = alu; bus.mem_load_data = ld;
    bus.mem_funct3 = f3; bus.stall = st; bus.flush = fl;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    check({tag, "_we"}, {31'd0, bus.write_enable}, {31'd0, m_we});
    check({tag, "_instret"}, bus.wb_instret, m_instret);
    if (m_known) begin
      check({tag, "_addr"}, bus.addr_rd, {27'd0, m_rd});
      check({tag, "_data"}, bus.data_rd, m_data);
    end
    e1 = (BYPASS && m_we && bus.id_addr_rs1 == m_rd) ? m_data : bus.id_data_rs1_in;
    e2 = (BYPASS && m_we && bus.id_addr_rs2 == m_rd) ? m_data : bus.id_data_rs2_in;
    check({tag, "_rs1"}, bus.id_data_rs1, e1);
    check({tag, "_rs2"}, bus.id_data_rs2, e2);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    bus.id_addr_rs1 = 5'd0; bus.id_addr_rs2 = 5'd0;
    bus.id_data_rs1_in = 32'hA5A5_0001; bus.id_data_rs2_in = 32'h5A5A_0002;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // lb / lbu at byte offset 3
    drive(1'b1, 32'h100, 5'd5, 1'b1, 2'd1, 32'h1003, 32'h80FF_7F01, 3'b000, 1'b0, 1'b0);
    tick();
    check("lb_data", bus.data_rd, 32'hFFFF_FF80);
    check("lb_we", {31'd0, bus.write_enable}, 32'd1);
    check("lb_addr", bus.addr_rd, 32'd5);
    bus.mem_funct3 = 3'b100;
    tick();
    check("lbu_data", bus.data_rd, 32'h0000_0080);

    // lh / lhu
    drive(1'b1, 32'h104, 5'd6, 1'b1, 2'd1, 32'h2002, 32'h8001_7FFF, 3'b001, 1'b0, 1'b0);
    tick();
    check("lh_off2", bus.data_rd, 32'hFFFF_8001);
    bus.mem_alu_result = 32'h2000; bus.mem_funct3 = 3'b101;
    tick();
    check("lhu_off0", bus.data_rd, 32'h0000_7FFF);
    bus.mem_alu_result = 32'h2003; bus.mem_funct3 = 3'b001;
    tick();
    check("lh_off3", bus.data_rd, 32'hFFFF_8001);

    // rd = 0 never writes; JAL link wraps
    drive(1'b1, 32'h108, 5'd0, 1'b1, 2'd0, 32'h1111, 32'd0, 3'd0, 1'b0, 1'b0);
    tick();
    check("rd0_we", {31'd0, bus.write_enable}, 32'd0);
    drive(1'b1, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    tick();
    check("jal_data", bus.data_rd, 32'h0000_0000);
    check("jal_we", {31'd0, bus.write_enable}, 32'd1);
    check_all("jal");

    // Asynchronous reset between edges while a write is presented
    #2;
    reset = 1'b1;
    #1;
    check("areset_we", {31'd0, bus.write_enable}, 32'd0);
    check("areset_data", bus.data_rd, 32'd0);
    check("areset_instret", bus.wb_instret, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Three captures, two stalls, then flush with stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i) * 32'd4, 5'(i + 10), 1'b1, 2'd0, 32'hC0DE_0000 + 32'(i),
            32'd0, 3'd2, 1'b0, 1'b0);
      tick();
    end
    check("cnt3", bus.wb_instret, 32'd3);
    drive(1'b1, 32'h300, 5'd20, 1'b1, 2'd0, 32'hBAD0_BAD0, 32'd0, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_data", bus.data_rd, 32'hC0DE_0002);
      check("stall_addr", bus.addr_rd, 32'd12);
      check("stall_instret", bus.wb_instret, 32'd3);
    end
    bus.flush = 1'b1;
    tick();
    check("flush_we", {31'd0, bus.write_enable}, 32'd0);
    check("flush_instret", bus.wb_instret, 32'd3);

    // Bypass into decode
    drive(1'b1, 32'h400, 5'd7, 1'b1, 2'd0, 32'h0000_1234, 32'd0, 3'd2, 1'b0, 1'b0);
    bus.id_addr_rs1 = 5'd7; bus.id_data_rs1_in = 32'h0000_DEAD;
    bus.id_addr_rs2 = 5'd8; bus.id_data_rs2_in = 32'h0000_BEEF;
    tick();
    check("byp_rs1", bus.id_data_rs1, BYPASS ? 32'h0000_1234 : 32'h0000_DEAD);
    check("byp_rs2", bus.id_data_rs2, 32'h0000_BEEF);
    check_all("byp");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom()),
            1'($urandom_range(0, 4) != 0), 2'($urandom()), $urandom(), $urandom(),
            3'($urandom()), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
      bus.id_addr_rs1 = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom());
      bus.id_addr_rs2 = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom());
      bus.id_data_rs1_in = $urandom();
      bus.id_data_rs2_in = $urandom();
      tick();
      bus.id_addr_rs1 = ($urandom_range(0, 1) == 0) ? m_rd : bus.id_addr_rs1;
      #1;
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
